// File: rtl/sr_bank_driver_if.sv
// Request/feedback bundle between control logic, sr_bank_driver and the SR bank.
// The slave side is the driver; Q arrives from the bank but travels with the bundle.
interface sr_bank_driver_if #(
    parameter int WIDTH = 4
);
    logic             REQ_VALID;
    logic [WIDTH-1:0] REQ_DATA;
    logic             REQ_READY;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (
        output REQ_VALID, REQ_DATA, Q,
        input  REQ_READY, S, R, BUSY, DONE, ERR
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, Q,
        output REQ_READY, S, R, BUSY, DONE, ERR
    );
endinterface

// File: rtl/sr_bank_driver.sv
// Drives non-overlapping S/R pulses into an SR flip-flop bank to reach a target
// word, then waits for Q to match (DONE) or gives up after a timeout (ERR).
module sr_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int PULSE_CYC = 2,
    parameter int TIMEOUT   = 8
) (
    input  logic            CLK,
    input  logic            RST,
    sr_bank_driver_if.slave bus
);
    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [CW-1:0]    ccnt_q, ccnt_d;

    logic [WIDTH-1:0] set_m, rst_m;

    // set and clear masks are disjoint by construction, so S&R can never overlap
    assign set_m = bus.REQ_DATA & ~bus.Q;
    assign rst_m = ~bus.REQ_DATA & bus.Q;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        s_d     = s_q;
        r_d     = r_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        pcnt_d  = pcnt_q;
        ccnt_d  = ccnt_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                s_d     = '0;
                r_d     = '0;
                if (ready_q && bus.REQ_VALID) begin
                    tgt_d   = bus.REQ_DATA;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    pcnt_d  = '0;
                    ccnt_d  = '0;
                    if ((set_m | rst_m) != '0) begin
                        state_d = DRIVE;
                        s_d     = set_m;
                        r_d     = rst_m;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            DRIVE: begin
                if (pcnt_q == P_LAST) begin
                    s_d     = '0;
                    r_d     = '0;
                    ccnt_d  = '0;
                    state_d = CHECK;
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            CHECK: begin
                s_d = '0;
                r_d = '0;
                // BUSY stays high through the DONE/ERR cycle; IDLE drops it next edge
                if (bus.Q == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (ccnt_q == C_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    ccnt_d = ccnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            s_q     <= '0;
            r_q     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pcnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pcnt_q  <= pcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.R         = r_q;
    assign bus.REQ_READY = ready_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
endmodule
